buffer_read_packer: RTL
=======================

// Module: buffer_read_packer
// PURPOSE
//  Read-side controller for the parallel circular buffer. It drains the buffer's
//  narrow read port, issuing one buf_ren per beat when the buffer is non-empty.
//  It packs PACK consecutive read beats into one wide word for the downstream
//  consumer, using a valid/ready handshake.
//  It is the counterpart of the wide parallel-write producer feeding the same buffer.
// PARAMETERS
//  WIDTH  16  bits per buffer element
//  PR      1  elements per buffer read beat (buffer read parallelism)
//  PACK    4  read beats packed per output word (>=2)
// PORTS
//  clk        input   1                    clock; all logic on rising edge
//  rst        input   1                    asynchronous, active-low reset
//  buf_empty  input   1                    buffer empty flag
//  buf_valid  input   1                    buf_dout holds a beat answering a prior buf_ren
//  buf_dout   input   PR*WIDTH             buffer read data
//  buf_ren    output  1                    read strobe to buffer; one-cycle pulse per beat
//  flush      input   1                    emit partially packed word now
//  out_ready  input   1                    downstream accepts out_data
//  out_valid  output  1                    out_data/out_count valid
//  out_data   output  PACK*PR*WIDTH        packed word; beat 0 in bits [PR*WIDTH-1:0]
//  out_count  output  $clog2(PACK+1)       number of valid beats in out_data (1..PACK)
//  busy       output  1                    state != IDLE or partial beats held
//  err        output  1                    sticky: buf_valid seen outside WAIT
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, beat_cnt=0, flush_pend=0.
//   All outputs are 0 (buf_ren, out_valid, out_data, out_count, busy, err).
//  FSM states: IDLE, REQ, WAIT, HOLD.
//  IDLE:
//   - If flush (or flush_pend) and beat_cnt>0: go to HOLD with out_count=beat_cnt.
//   - Else if !buf_empty: go to REQ.
//   - Else stay in IDLE.
//   - flush with beat_cnt==0 is dropped; there is no empty output word.
//  REQ: buf_ren=1 for exactly this cycle; next state is WAIT.
//  WAIT: buf_ren=0; wait any number of cycles for buf_valid (no timeout).
//   On buf_valid:
//   - buf_dout goes to slot beat_cnt, bits [(beat_cnt+1)*PR*WIDTH-1 : beat_cnt*PR*WIDTH].
//   - beat_cnt increments.
//   - If the new beat_cnt==PACK: go to HOLD, out_count=PACK.
//   - Else if flush_pend: go to HOLD, out_count=beat_cnt.
//   - Else if !buf_empty: go to REQ.
//   - Else go to IDLE.
//  HOLD: out_valid=1. out_data and out_count stay stable until out_ready.
//   On out_valid && out_ready:
//   - beat_cnt and flush_pend clear to 0.
//   - Next state is REQ if !buf_empty, else IDLE.
//   - out_data keeps its value; it is don't-care once out_valid=0.
//  Output latency:
//   - First out_valid comes no earlier than 2*PACK cycles after buf_empty falls in IDLE.
//   - With one-cycle buffer latency, each beat costs 2 cycles (REQ + WAIT).
//  Slots not written in a partial word read as 0. Packing is cleared on HOLD exit.
//  flush asserted in REQ/WAIT sets flush_pend; it is serviced after the in-flight beat lands.
//   flush in HOLD is ignored.
//  Overflow/underflow:
//   - The block never asserts buf_ren while buf_empty=1.
//   - It never holds more than one outstanding read.
//   - It never issues a read while in HOLD; downstream backpressure stalls the buffer.
//  buf_valid outside WAIT: the data is ignored and err is set. err is cleared only by reset.
//  buf_valid in the same cycle as the REQ pulse is ignored and sets err
//   (buffer read latency must be >=1).
//  Reset mid-operation discards partial beats and any held word. No buf_ren follows reset
//   until the FSM re-enters REQ.
// TESTING
//  1 WIDTH=16 PR=1 PACK=4: buffer preloaded 5,1,8,12.
//    -> 4 buf_ren pulses; out_data=0x000C_0008_0001_0005, out_count=4.
//  2 Backpressure: out_ready=0 for 10 cycles in HOLD.
//    -> out_data stable, no buf_ren while buffer holds 4 more words.
//    -> After out_ready=1, next word is 0x00AA_0096_0082_0078 (120,130,150,170).
//  3 Two words 0x0011,0x0022, then empty; pulse flush.
//    -> out_data=0x0000_0000_0022_0011, out_count=2.
//  4 flush pulsed during WAIT of beat 1 (0x0033).
//    -> flush_pend set; HOLD right after capture, out_count=1, out_data low 16 bits 0x0033.
//  5 buf_valid injected in IDLE -> err=1 and sticky; beat_cnt unchanged; clears only on rst=0.
//  6 rst=0 asserted in WAIT after 2 captured beats.
//    -> All outputs 0 at once; after release, the next word restarts at slot 0.

Source files
------------

// File: rtl/buffer_read_packer.sv
// Read-side controller for the parallel circular buffer: drains the buffer one
// beat at a time and packs PACK beats into one wide word behind a valid/ready handshake.
module buffer_read_packer #(
  parameter int WIDTH = 16,
  parameter int PR    = 1,
  parameter int PACK  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         buf_empty,
  input  logic                         buf_valid,
  input  logic [PR*WIDTH-1:0]          buf_dout,
  output logic                         buf_ren,
  input  logic                         flush,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [PACK*PR*WIDTH-1:0]     out_data,
  output logic [$clog2(PACK+1)-1:0]    out_count,
  output logic                         busy,
  output logic                         err
);

  localparam int BW = PR * WIDTH;
  localparam int OW = PACK * BW;
  localparam int CW = $clog2(PACK + 1);
  localparam logic [CW-1:0] PACK_C = CW'(PACK);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t         state;
  logic [CW-1:0]  beat_cnt;
  logic [CW-1:0]  beat_nxt;
  logic           flush_pend;

  assign beat_nxt = beat_cnt + CW'(1);
  assign busy     = (state != IDLE) || (beat_cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
      buf_ren    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
      err        <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; a later assignment in the case wins,
      // so buf_ren is a single-cycle pulse without a separate clear path.
      buf_ren <= 1'b0;

      // Data only answers a read while waiting for it; anything else is a protocol fault.
      if (buf_valid && state != WAIT) err <= 1'b1;

      case (state)
        IDLE: begin
          if ((flush || flush_pend) && beat_cnt != '0) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_count <= beat_cnt;
          end else if (!buf_empty) begin
            state   <= REQ;
            buf_ren <= 1'b1;
          end
        end

        REQ: begin
          state <= WAIT;
          if (flush) flush_pend <= 1'b1;
        end

        WAIT: begin
          if (buf_valid) begin
            // Slot 0 write also zeroes the upper slots, so a partial word never
            // carries beats of the previous one while out_data stays untouched after HOLD.
            if (beat_cnt == '0) out_data <= OW'(buf_dout);
            else                out_data[beat_cnt*BW +: BW] <= buf_dout;
            beat_cnt <= beat_nxt;
            if (beat_nxt == PACK_C) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_count <= PACK_C;
            end else if (flush_pend || flush) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_count <= beat_nxt;
            end else if (!buf_empty) begin
              state   <= REQ;
              buf_ren <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            beat_cnt   <= '0;
            flush_pend <= 1'b0;
            if (!buf_empty) begin
              state   <= REQ;
              buf_ren <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
